// File: rtl/addition_stage5_if.sv
// Handshake and data bundle between the normalization stage, the rounding stage
// and the writeback consumer. The slave view belongs to the rounding stage.
interface addition_stage5_if #(
   parameter int MENT_WIDTH = 23,
   parameter int EXPO_WIDTH = 8
);
   logic                             valid_in;
   logic                             ready_out;
   logic                             sign_in;
   logic [MENT_WIDTH-1:0]            normalized_mentissa_in;
   logic [EXPO_WIDTH-1:0]            normalized_exponent_in;
   logic [2:0]                       grs_in;
   logic [1:0]                       rm_in;
   logic                             valid_out;
   logic                             ready_in;
   logic [EXPO_WIDTH+MENT_WIDTH:0]   result_out;
   logic                             inexact_out;
   logic                             overflow_out;

   modport slave (
      input  valid_in, sign_in, normalized_mentissa_in, normalized_exponent_in,
             grs_in, rm_in, ready_in,
      output ready_out, valid_out, result_out, inexact_out, overflow_out
   );

   modport master (
      output valid_in, sign_in, normalized_mentissa_in, normalized_exponent_in,
             grs_in, rm_in, ready_in,
      input  ready_out, valid_out, result_out, inexact_out, overflow_out
   );
endinterface

// File: rtl/addition_stage5.sv
// FP adder rounding stage: applies the rounding mode to a normalized fraction,
// renormalizes on carry-out and saturates on exponent overflow. Two-deep stallable pipe.
module addition_stage5 #(
   parameter int MENT_WIDTH = 23,
   parameter int EXPO_WIDTH = 8
) (
   input logic              clk,
   input logic              rst,
   addition_stage5_if.slave bus
);
   typedef enum logic [1:0] {
      RM_RNE = 2'b00,
      RM_RTZ = 2'b01,
      RM_RUP = 2'b10,
      RM_RDN = 2'b11
   } round_mode_t;

   localparam logic [EXPO_WIDTH-1:0] EXP_MAX = {EXPO_WIDTH{1'b1}};
   localparam logic [EXPO_WIDTH-1:0] EXP_TOP = {{(EXPO_WIDTH-1){1'b1}}, 1'b0};

   round_mode_t           rm;
   logic                  adv;
   logic                  guard_bit, round_bit, sticky_bit, any_grs;
   logic                  near_inc, inc, to_inf_next;
   logic [MENT_WIDTH:0]   sum_next;
   logic                  inexact_next, ovf_next;

   logic                  a_valid, a_sign, a_inexact, a_ovf, a_to_inf;
   logic [EXPO_WIDTH-1:0] a_exp;
   logic [MENT_WIDTH:0]   a_sum;

   logic [EXPO_WIDTH-1:0] b_exp;
   logic [MENT_WIDTH-1:0] b_frac;
   logic                  b_inexact, b_ovf;

   logic                            valid_q, inexact_q, overflow_q;
   logic [EXPO_WIDTH+MENT_WIDTH:0]  result_q;

   assign rm  = round_mode_t'(bus.rm_in);
   assign adv = !valid_q || bus.ready_in;
   assign {guard_bit, round_bit, sticky_bit} = bus.grs_in;
   assign any_grs = |bus.grs_in;

   // Overflow is flagged when either the selected mode or round-to-nearest would
   // carry past the top finite exponent; the mode then picks infinity or max-finite.
   always_comb begin
      near_inc     = guard_bit && (round_bit || sticky_bit || bus.normalized_mentissa_in[0]);
      inc          = 1'b0;
      to_inf_next  = 1'b0;
      case (rm)
         RM_RNE: begin inc = near_inc;                 to_inf_next = 1'b1;          end
         RM_RTZ: begin inc = 1'b0;                     to_inf_next = 1'b0;          end
         RM_RUP: begin inc = !bus.sign_in && any_grs;  to_inf_next = !bus.sign_in;  end
         RM_RDN: begin inc = bus.sign_in && any_grs;   to_inf_next = bus.sign_in;   end
         default: begin inc = 1'b0;                    to_inf_next = 1'b0;          end
      endcase
      sum_next     = {1'b0, bus.normalized_mentissa_in} + {{MENT_WIDTH{1'b0}}, inc};
      inexact_next = any_grs;
      ovf_next     = (bus.normalized_exponent_in == EXP_TOP) &&
                     (&bus.normalized_mentissa_in) && (inc || near_inc);
      if (bus.normalized_exponent_in == EXP_MAX) begin
         sum_next     = {1'b0, bus.normalized_mentissa_in};
         inexact_next = 1'b0;
         ovf_next     = 1'b0;
      end else if (bus.normalized_exponent_in == '0) begin
         sum_next     = '0;
         inexact_next = any_grs || (|bus.normalized_mentissa_in);
         ovf_next     = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_valid   <= 1'b0;
         a_sign    <= 1'b0;
         a_exp     <= '0;
         a_sum     <= '0;
         a_inexact <= 1'b0;
         a_ovf     <= 1'b0;
         a_to_inf  <= 1'b0;
      end else if (adv) begin
         a_valid   <= bus.valid_in;
         a_sign    <= bus.sign_in;
         a_exp     <= bus.normalized_exponent_in;
         a_sum     <= sum_next;
         a_inexact <= inexact_next;
         a_ovf     <= ovf_next;
         a_to_inf  <= to_inf_next;
      end
   end

   always_comb begin
      b_exp     = a_exp;
      b_frac    = a_sum[MENT_WIDTH-1:0];
      b_inexact = a_inexact;
      b_ovf     = 1'b0;
      if (a_ovf) begin
         b_ovf     = 1'b1;
         b_inexact = 1'b1;
         b_exp     = a_to_inf ? EXP_MAX : EXP_TOP;
         b_frac    = a_to_inf ? '0 : '1;
      end else if (a_sum[MENT_WIDTH]) begin
         b_frac = '0;
         b_exp  = a_exp + 1'b1;
      end
      if (!a_valid) begin
         b_inexact = 1'b0;
         b_ovf     = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q    <= 1'b0;
         result_q   <= '0;
         inexact_q  <= 1'b0;
         overflow_q <= 1'b0;
      end else if (adv) begin
         valid_q    <= a_valid;
         result_q   <= {a_sign, b_exp, b_frac};
         inexact_q  <= b_inexact;
         overflow_q <= b_ovf;
      end
   end

   assign bus.ready_out    = adv;
   assign bus.valid_out    = valid_q;
   assign bus.result_out   = result_q;
   assign bus.inexact_out  = inexact_q;
   assign bus.overflow_out = overflow_q;
endmodule

// File: tb/tb_addition_stage5.sv
// Scoreboard bench for the rounding stage: randomized and directed operands are
// scored against an arithmetic rounding model while the downstream ready toggles.
module tb_addition_stage5;
   logic clk = 1'b0;
   logic rst = 1'b0;
   int   checks = 0;
   int   failures = 0;
   int   cyc = 0;
   int   accept_cyc = 0;
   int   sent = 0;
   int   received = 0;
   bit   random_ready = 1'b0;
   bit   hold_valid = 1'b0;
   logic [31:0] held_result;
   logic [33:0] exp_q[$];

   addition_stage5_if #(.MENT_WIDTH(23), .EXPO_WIDTH(8)) bus();

   addition_stage5 #(.MENT_WIDTH(23), .EXPO_WIDTH(8)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   // Returns {overflow, inexact, result} for one operand using integer significands.
   function automatic logic [33:0] refModel(input logic s, input logic [22:0] f,
                                            input logic [7:0] e, input logic [2:0] grs,
                                            input logic [1:0] rm);
      int sig, sig_mode, sig_near, exp_mode, exp_near;
      bit up_mode, up_near, to_inf;
      if (e == 8'hFF) return {2'b00, s, e, f};
      if (e == 8'h00) return {1'b0, (grs != 0 || f != 0), s, 31'd0};
      sig     = (1 << 23) + int'(f);
      up_near = (grs > 3'd4) || (grs == 3'd4 && sig % 2 == 1);
      case (rm)
         2'd0:    up_mode = up_near;
         2'd1:    up_mode = 1'b0;
         2'd2:    up_mode = (grs != 0) && !s;
         default: up_mode = (grs != 0) && s;
      endcase
      sig_near = sig + int'(up_near);
      exp_near = int'(e);
      if (sig_near == (1 << 24)) begin sig_near = 1 << 23; exp_near++; end
      sig_mode = sig + int'(up_mode);
      exp_mode = int'(e);
      if (sig_mode == (1 << 24)) begin sig_mode = 1 << 23; exp_mode++; end
      to_inf = (rm == 2'd0) || (rm == 2'd2 && !s) || (rm == 2'd3 && s);
      if (exp_mode == 255 || exp_near == 255)
         return to_inf ? {2'b11, s, 8'hFF, 23'h000000} : {2'b11, s, 8'hFE, 23'h7FFFFF};
      return {1'b0, (grs != 0), s, 8'(exp_mode), 23'(sig_mode)};
   endfunction

   task automatic checkOutput(input string name, input logic [63:0] actual,
                              input logic [63:0] required);
      checks++;
      if (actual !== required) begin
         failures++;
         $display("[TB] FAIL %s: got %0h, expected %0h at cycle %0d", name, actual, required, cyc);
      end
   endtask

   task automatic applyStimulus(input logic s, input logic [22:0] f, input logic [7:0] e,
                                input logic [2:0] grs, input logic [1:0] rm);
      int waited = 0;
      bus.sign_in                = s;
      bus.normalized_mentissa_in = f;
      bus.normalized_exponent_in = e;
      bus.grs_in                 = grs;
      bus.rm_in                  = rm;
      bus.valid_in               = 1'b1;
      @(negedge clk);
      while (!bus.ready_out && waited < 200) begin
         @(negedge clk);
         waited++;
      end
      if (!bus.ready_out) begin
         checkOutput("accept_timeout", 64'(bus.ready_out), 64'd1);
      end else begin
         exp_q.push_back(refModel(s, f, e, grs, rm));
         accept_cyc = cyc;
         sent++;
      end
      @(posedge clk);
      #1 bus.valid_in = 1'b0;
   endtask

   task automatic waitDrain();
      int n = 0;
      while (exp_q.size() != 0 && n < 400) begin
         @(negedge clk);
         n++;
      end
      checkOutput("drain_empty", 64'(exp_q.size()), 64'd0);
      checkOutput("out_count", 64'(received), 64'(sent));
      @(posedge clk);
      #1;
   endtask

   task automatic measureLatency(input logic [22:0] f);
      int n = 0;
      applyStimulus(1'b0, f, 8'h40, 3'b011, 2'd0);
      do begin
         @(negedge clk);
         n++;
      end while (!bus.valid_out && n < 20);
      checkOutput("latency", 64'(cyc - accept_cyc), 64'd2);
      @(posedge clk);
      #1;
   endtask

   // Monitor: pops one expectation per completed transfer and watches held data during stalls.
   always @(negedge clk) begin
      if (!rst) begin
         if (bus.valid_out) begin
            if (hold_valid) checkOutput("stall_stable", 64'(bus.result_out), 64'(held_result));
            if (bus.ready_in) begin
               hold_valid = 1'b0;
               if (exp_q.size() == 0) begin
                  checkOutput("unexpected_output", 64'(bus.result_out), 64'hDEAD);
               end else begin
                  logic [33:0] e;
                  e = exp_q.pop_front();
                  received++;
                  checkOutput("result", 64'(bus.result_out), 64'(e[31:0]));
                  checkOutput("inexact", 64'(bus.inexact_out), 64'(e[32]));
                  checkOutput("overflow", 64'(bus.overflow_out), 64'(e[33]));
               end
            end else begin
               held_result = bus.result_out;
               hold_valid  = 1'b1;
            end
         end else begin
            hold_valid = 1'b0;
         end
      end
   end

   always begin
      @(posedge clk);
      #1;
      if (random_ready) bus.ready_in = ($urandom_range(0, 9) < 7);
   end

   initial begin
      bit saw_stall;
      logic [22:0] f;
      logic [7:0]  e;
      bus.valid_in = 1'b0;
      bus.sign_in = 1'b0;
      bus.normalized_mentissa_in = '0;
      bus.normalized_exponent_in = '0;
      bus.grs_in = '0;
      bus.rm_in = '0;
      bus.ready_in = 1'b0;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("reset_valid", 64'(bus.valid_out), 64'd0);
      checkOutput("reset_result", 64'(bus.result_out), 64'd0);
      checkOutput("reset_flags", 64'({bus.inexact_out, bus.overflow_out}), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      bus.ready_in = 1'b1;
      @(posedge clk);
      #1;

      applyStimulus(1'b0, 23'h000001, 8'h80, 3'b100, 2'd0);
      applyStimulus(1'b0, 23'h000002, 8'h80, 3'b100, 2'd0);
      applyStimulus(1'b0, 23'h7FFFFF, 8'h80, 3'b110, 2'd0);
      applyStimulus(1'b0, 23'h7FFFFF, 8'hFE, 3'b111, 2'd0);
      applyStimulus(1'b0, 23'h7FFFFF, 8'hFE, 3'b111, 2'd1);
      applyStimulus(1'b1, 23'h7FFFFF, 8'hFE, 3'b001, 2'd3);
      applyStimulus(1'b1, 23'h7FFFFF, 8'hFE, 3'b001, 2'd2);
      applyStimulus(1'b0, 23'h7FFFFF, 8'hFE, 3'b001, 2'd0);
      applyStimulus(1'b1, 23'h123456, 8'hFF, 3'b111, 2'd2);
      applyStimulus(1'b1, 23'h000010, 8'h00, 3'b000, 2'd0);
      applyStimulus(1'b0, 23'h000000, 8'h00, 3'b000, 2'd0);
      waitDrain();
      measureLatency(23'h00ABCD);
      waitDrain();

      saw_stall = 1'b0;
      fork
         begin
            for (int i = 0; i < 4; i++)
               applyStimulus(i[0], 23'(32'h7FFFF0 + i * 7), 8'h90, 3'(i + 4), 2'(i));
         end
         begin
            @(posedge clk);
            #1 bus.ready_in = 1'b0;
            repeat (4) begin
               @(negedge clk);
               if (!bus.ready_out) saw_stall = 1'b1;
               @(posedge clk);
               #1;
            end
            bus.ready_in = 1'b1;
         end
      join
      checkOutput("t5_ready_low", 64'(saw_stall), 64'd1);
      waitDrain();

      random_ready = 1'b1;
      for (int i = 0; i < 300; i++) begin
         case ($urandom_range(0, 3))
            0: f = 23'h7FFFFF;
            1: f = 23'(($urandom_range(0, 1) == 0) ? 0 : 1);
            default: f = 23'($urandom);
         endcase
         case ($urandom_range(0, 5))
            0: e = 8'hFF;
            1: e = 8'h00;
            2: e = 8'hFE;
            default: e = 8'($urandom_range(1, 253));
         endcase
         applyStimulus(1'($urandom), f, e, 3'($urandom), 2'($urandom));
      end
      random_ready = 1'b0;
      @(posedge clk);
      #1 bus.ready_in = 1'b1;
      waitDrain();

      bus.ready_in = 1'b0;
      applyStimulus(1'b0, 23'h000111, 8'h70, 3'b101, 2'd0);
      applyStimulus(1'b1, 23'h000222, 8'h71, 3'b011, 2'd3);
      @(negedge clk);
      checkOutput("t6_pre_valid", 64'(bus.valid_out), 64'd1);
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      checkOutput("t6_async_valid", 64'(bus.valid_out), 64'd0);
      checkOutput("t6_async_result", 64'(bus.result_out), 64'd0);
      checkOutput("t6_ready", 64'(bus.ready_out), 64'd1);
      exp_q.delete();
      hold_valid = 1'b0;
      sent = 0;
      received = 0;
      @(negedge clk);
      rst = 1'b0;
      bus.ready_in = 1'b1;
      @(posedge clk);
      #1;
      measureLatency(23'h3C3C3C);
      waitDrain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
